multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multicycle MIPS main control unit. It replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds addi and bne support, latches the opcode at decode, and stalls on a memory-ready handshake.
- Drives the shared-memory multicycle datapath: PC, IR, MDR, A/B/ALUOut registers.

Parameters:
- OP_W, 6, opcode width
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch if equal
- OP_BNE, 6'h05, branch if not equal
- OP_J, 6'h02, jump
- OP_ADDI, 6'h08, add immediate
- STATE_W, 4, state register width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Op  in  OP_W  IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  conditional PC write (branch)
- BranchNe  out  1  invert the Zero condition for bne
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- MemtoReg  out  1  register write data: 1 = MDR
- IRWrite  out  1  IR load
- RegWrite  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext, 11 = signext<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector
- EPCWrite  out  1  EPC load (exception)
- CauseWrite  out  1  Cause load (exception)
- State  out  STATE_W  current state, for debug

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge: state <= FETCH (0) and op_q <= 0.
  - While rst_n=0, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, EPCWrite and CauseWrite are forced to 0 combinationally in the same cycle. All other outputs take their FETCH values.
  - Reset asserted mid-instruction aborts it; no partial write is issued after reset is seen.
- Outputs are a Moore decode of state, except that memory-state enables are gated by mem_ready as noted below. Every output not listed for a state is 0.
- State encodings and actions:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. op_q <= Op. Next state from Op:
    - lw or sw -> MEM_ADDR
    - R-type -> EXEC
    - beq or bne -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EXEC
    - any other opcode -> see Optional Feature
  - MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD if op_q==OP_LW, else MEM_WR.
  - MEM_RD (3): MemRead=1, IorD=1. Holds while mem_ready=0; goes to MEM_WB when mem_ready=1.
  - MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEM_WR (5): MemWrite=1, IorD=1. Holds while mem_ready=0; goes to FETCH when mem_ready=1. MemWrite stays asserted throughout the hold.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
  - R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(op_q==OP_BNE). Goes to FETCH.
  - JUMP (9): PCWrite=1, PCSource=10. Goes to FETCH.
  - ADDI_EXEC (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
  - ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
  - TRAP (12): see Optional Feature.
- Any unused encoding (13-15) -> FETCH next cycle with all outputs 0.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, bne, j: 3 cycles
  - Each cycle mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_EXCEPTION_EN.
- Defined:
  - An undefined opcode in DECODE -> TRAP.
  - TRAP asserts EPCWrite=1, CauseWrite=1, PCWrite=1, PCSource=11, ALUSrcA=0, ALUSrcB=01, ALUOp=01 (EPC = PC-4). Goes to FETCH next cycle.
- Not defined:
  - TRAP does not exist; an undefined opcode goes DECODE -> FETCH and is executed as a 2-cycle NOP.
  - EPCWrite and CauseWrite are tied to 0.

Test Plan:
- Reset, then lw (Op=6'h23), mem_ready=1 -> State sequence 0,1,2,3,4,0. IRWrite=1 only in cycle 0. RegWrite=1 with MemtoReg=1 only in state 4.
- sw (6'h2B) with mem_ready=0 for 2 cycles in MEM_WR -> State 0,1,2,5,5,5,0. MemWrite=1 for all 3 MEM_WR cycles. RegWrite never asserted.
- beq (6'h04), then bne (6'h05) -> State 0,1,8,0 each time. PCWriteCond=1 in state 8. BranchNe=0 for beq, 1 for bne. In both cases Op is changed to 6'h00 during BRANCH and the result is unchanged.
- R-type (6'h00), then addi (6'h08), then j (6'h02) -> R-type: RegDst=1 in state 7. addi: states 10,11 with RegDst=0. j: state 9 with PCWrite=1 and PCSource=10.
- rst_n driven low while in MEM_WR with MemWrite=1 -> MemWrite=0 in that same cycle; State=0 after the next edge. Holding rst_n=0 for 3 cycles keeps State=0 and every write enable at 0.
- Op=6'h3F -> macro defined: State 0,1,12,0 with EPCWrite=CauseWrite=PCWrite=1 and PCSource=11 in state 12. Macro undefined: State 0,1,0 with no write enables after FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and datapath control outputs of the multicycle control unit.
interface multicycle_control_if #(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
);
    logic [OP_W-1:0]    Op;
    logic               mem_ready;
    logic               PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic               RegWrite, RegDst, ALUSrcA, EPCWrite, CauseWrite;
    logic [1:0]         ALUSrcB, ALUOp, PCSource;
    logic [STATE_W-1:0] State;
    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
        output RegWrite, RegDst, ALUSrcA, EPCWrite, CauseWrite, ALUSrcB, ALUOp, PCSource, State
    );
    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
        input  RegWrite, RegDst, ALUSrcA, EPCWrite, CauseWrite, ALUSrcB, ALUOp, PCSource, State
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath with a memory-ready stall.
// Define MULTICYCLE_CONTROL_EXCEPTION_EN to trap undefined opcodes; otherwise they execute as a NOP.
module multicycle_control #(
    parameter int              OP_W     = 6,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
    parameter logic [OP_W-1:0] OP_LW    = 6'h23,
    parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
    parameter logic [OP_W-1:0] OP_BNE   = 6'h05,
    parameter logic [OP_W-1:0] OP_J     = 6'h02,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'h08,
    parameter int              STATE_W  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB,
        BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP
    } state_t;

    state_t          state_q, state_d, st, illegal;
    logic [OP_W-1:0] op_q, op_d;

`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
    assign illegal = TRAP;
`else
    assign illegal = FETCH;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // During reset the outputs decode as FETCH so nothing from an aborted instruction leaks out
    assign st        = rst_n ? state_q : FETCH;
    assign bus.State = state_q;

    always_comb begin
        state_d         = FETCH;
        op_d            = op_q;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.EPCWrite    = 1'b0;
        bus.CauseWrite  = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        case (st)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                state_d     = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                op_d        = bus.Op;
                state_d     = (bus.Op == OP_LW || bus.Op == OP_SW)  ? MEM_ADDR :
                              (bus.Op == OP_RTYPE)                  ? EXEC :
                              (bus.Op == OP_BEQ || bus.Op == OP_BNE) ? BRANCH :
                              (bus.Op == OP_J)                      ? JUMP :
                              (bus.Op == OP_ADDI)                   ? ADDI_EXEC : illegal;
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_d     = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                state_d      = bus.mem_ready ? FETCH : MEM_WR;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = R_WB;
            end
            R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNe    = (op_q == OP_BNE);
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            ADDI_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = ADDI_WB;
            end
            ADDI_WB: bus.RegWrite = 1'b1;
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
            TRAP: begin
                bus.EPCWrite   = 1'b1;
                bus.CauseWrite = 1'b1;
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'b11;
                bus.ALUSrcB    = 2'b01;
                bus.ALUOp      = 2'b01;
            end
`endif
            default: state_d = FETCH;
        endcase
        if (!rst_n) begin
            {bus.PCWrite, bus.PCWriteCond, bus.MemRead, bus.MemWrite} = 4'b0000;
            {bus.IRWrite, bus.RegWrite, bus.EPCWrite, bus.CauseWrite} = 4'b0000;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random opcode/stall stimulus checked against a per-instruction state-path model.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    always #5 clk = ~clk;

    multicycle_control_if #(.OP_W(6), .STATE_W(4)) bus();
    multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected outputs of one cycle in state s, given the instruction's opcode and current mem_ready
    task automatic cyc(input int s, input logic [5:0] op);
        logic rdy;
        #1;
        rdy = bus.mem_ready;
        chk("State", 32'(bus.State), 32'(s));
        chk("IRWrite", 32'(bus.IRWrite), 32'(s == 0 && rdy));
        chk("PCWrite", 32'(bus.PCWrite), 32'((s == 0 && rdy) || s == 9 || s == 12));
        chk("PCWriteCond", 32'(bus.PCWriteCond), 32'(s == 8));
        chk("BranchNe", 32'(bus.BranchNe), 32'(s == 8 && op == 6'h05));
        chk("MemRead", 32'(bus.MemRead), 32'(s == 0 || s == 3));
        chk("MemWrite", 32'(bus.MemWrite), 32'(s == 5));
        chk("IorD", 32'(bus.IorD), 32'(s == 3 || s == 5));
        chk("RegWrite", 32'(bus.RegWrite), 32'(s == 4 || s == 7 || s == 11));
        chk("MemtoReg", 32'(bus.MemtoReg), 32'(s == 4));
        chk("RegDst", 32'(bus.RegDst), 32'(s == 7));
        chk("ALUSrcA", 32'(bus.ALUSrcA), 32'(s == 2 || s == 6 || s == 8 || s == 10));
        chk("ALUSrcB", 32'(bus.ALUSrcB), (s == 0 || s == 12) ? 32'd1 : s == 1 ? 32'd3 : (s == 2 || s == 10) ? 32'd2 : 32'd0);
        chk("ALUOp", 32'(bus.ALUOp), s == 6 ? 32'd2 : (s == 8 || s == 12) ? 32'd1 : 32'd0);
        chk("PCSource", 32'(bus.PCSource), s == 8 ? 32'd1 : s == 9 ? 32'd2 : s == 12 ? 32'd3 : 32'd0);
        chk("EPCWrite", 32'(bus.EPCWrite), 32'(s == 12));
        chk("CauseWrite", 32'(bus.CauseWrite), 32'(s == 12));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op);
        int path[$];
        int n;
        int cycles;
        int stalls;
        path = '{0, 1};
        case (op)
            6'h23: path = {path, 2, 3, 4};
            6'h2B: path = {path, 2, 5};
            6'h00: path = {path, 6, 7};
            6'h08: path = {path, 10, 11};
            6'h04, 6'h05: path.push_back(8);
            6'h02: path.push_back(9);
            default: if (EXC) path.push_back(12);
        endcase
        cycles = 0;
        stalls = 0;
        foreach (path[k]) begin
            if (path[k] == 0 || path[k] == 3 || path[k] == 5) begin
                n = $urandom_range(0, 2);
                stalls += n;
                repeat (n) begin
                    bus.mem_ready = 1'b0;
                    bus.Op = (path[k] == 0) ? op : 6'($urandom);
                    cyc(path[k], op);
                    cycles++;
                end
                bus.mem_ready = 1'b1;
            end else
                bus.mem_ready = 1'($urandom_range(0, 1));
            bus.Op = (path[k] <= 1) ? op : 6'($urandom);
            cyc(path[k], op);
            cycles++;
        end
        chk("latency", 32'(cycles), 32'(stalls + (op == 6'h23 ? 5 :
            (op == 6'h2B || op == 6'h00 || op == 6'h08) ? 4 :
            (op == 6'h04 || op == 6'h05 || op == 6'h02) ? 3 : (EXC ? 3 : 2))));
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h00, 6'h08, 6'h02, 6'h3F};
        bus.Op = 6'h2B;
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_MemRead", 32'(bus.MemRead), 0);
        chk("rst_IRWrite", 32'(bus.IRWrite), 0);
        chk("rst_PCWrite", 32'(bus.PCWrite), 0);
        chk("rst_ALUSrcB", 32'(bus.ALUSrcB), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_State", 32'(bus.State), 0);
        rst_n = 1'b1;
        foreach (ops[i]) run_instr(ops[i]);
        bus.mem_ready = 1'b1;
        bus.Op = 6'h2B;
        cyc(0, 6'h2B);
        cyc(1, 6'h2B);
        cyc(2, 6'h2B);
        bus.mem_ready = 1'b0;
        cyc(5, 6'h2B);
        chk("memwr_hold", 32'(bus.MemWrite), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_State", 32'(bus.State), 5);
        chk("abort_MemWrite", 32'(bus.MemWrite), 0);
        chk("abort_IorD", 32'(bus.IorD), 0);
        chk("abort_ALUSrcB", 32'(bus.ALUSrcB), 1);
        @(posedge clk);
        #1;
        repeat (3) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("hold_State", 32'(bus.State), 0);
            chk("hold_enables", 32'({bus.PCWrite, bus.PCWriteCond, bus.MemRead, bus.MemWrite,
                                     bus.IRWrite, bus.RegWrite, bus.EPCWrite, bus.CauseWrite}), 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            run_instr(op);
        end
        bus.mem_ready = 1'b1;
        cyc(0, 6'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
